tx_pattern_gen: RTL and testbench
=================================

// Module: tx_pattern_gen
// PURPOSE
//  Parametrised UART transmit stimulus source; successor to the fixed 1-byte/50000-clk counter source.
//  Emits a burst of BURST_LEN words every PERIOD clocks over a valid/ready handshake to the UART TX.
//  Pattern modes: increment, decrement, PRBS (LFSR), fixed; run-time enable and mode select.
//  Sits between board-level control (switch/enable) and the uart_tx serialiser.
// PARAMETERS
//  DATA_W     8      word width; legal values 8 or 16 (LFSR taps defined only for these)
//  PERIOD     50000  clocks from burst end (or start) to next burst start; >=2
//  BURST_LEN  1      words per burst; 1..255
//  SEED       8'h01  initial pattern value; if 0 in PRBS mode, 1 is used instead
//  FIXED_VAL  8'h55  word sent in FIXED mode (zero-extended to DATA_W)
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  rst        in   1       asynchronous, active-high reset
//  enable     in   1       level; 1 = generate bursts, 0 = stop after current handshake
//  mode       in   2       0 INC, 1 DEC, 2 PRBS, 3 FIXED; sampled only on IDLE->WAIT
//  tx_data    out  DATA_W  word presented to UART TX
//  tx_valid   out  1       tx_data is valid; held until accepted
//  tx_ready   in   1       UART TX can accept (i.e. !tx_busy)
//  busy       out  1       high in WAIT or SEND
//  sent_cnt   out  16      accepted-word counter, wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset (async assert, sync deassert handled upstream): state=IDLE, tx_valid=0, tx_data=0,
//   busy=0, sent_cnt=0, period cnt=0, burst cnt=0, pattern reg=SEED, mode_r=0.
//  States: IDLE, WAIT, SEND.
//  IDLE: enable=1 -> WAIT next clk; mode_r<=mode, pattern reg<=SEED (PRBS: SEED==0 -> 1), cnt<=0.
//  WAIT: cnt increments each clk; cnt==PERIOD-1 -> SEND, cnt<=0, tx_valid<=1, tx_data<=pattern.
//   First word appears PERIOD+1 clks after enable rises. enable=0 in WAIT -> IDLE next clk.
//  SEND: transfer occurs on clk where tx_valid&&tx_ready; then sent_cnt++, pattern advances,
//   burst cnt++. If burst cnt==BURST_LEN-1 (last word) or enable==0: tx_valid<=0, burst cnt<=0,
//   next state WAIT (enable=1) or IDLE (enable=0). Else tx_valid stays 1, tx_data<=next pattern
//   (back-to-back, no bubble).
//  No retraction: once tx_valid=1, tx_valid and tx_data hold stable until accepted, regardless of enable.
//  Period counter does not run in SEND; PERIOD is measured from the end of one burst to the
//   start of the next; a stalled tx_ready stretches the interval, never drops words.
//  Pattern advance: INC p+1, DEC p-1 (mod 2^DATA_W, wrap); FIXED always FIXED_VAL;
//   PRBS Fibonacci LFSR shift-left, feedback into LSB = XOR of taps:
//   DATA_W=8: x^8+x^6+x^5+x^4+1; DATA_W=16: x^16+x^15+x^13+x^4+1. Never reaches 0.
//  mode changes outside IDLE are ignored until the next IDLE->WAIT.
//  rst asserted mid-burst: all state returns to reset values immediately; no partial word kept.
// STRUCTURE
//  Package uart_pat_pkg: mode enum (MODE_INC/DEC/PRBS/FIXED), state enum, LFSR tap masks
//   per DATA_W, function next_pattern(mode, p).
//  One sub-module: pattern_lfsr (DATA_W, SEED) with load/step inputs; INC/DEC/FIXED inline.
//  Top: FSM + period counter + burst counter + sent_cnt.
// TESTING
//  1 PERIOD=10,BURST_LEN=1,INC,SEED=0,tx_ready=1: words 00,01,02 at clks 11,22,33 after enable.
//  2 BURST_LEN=4,DEC,SEED=8'h02: back-to-back 02,01,00,FF with tx_valid high 4 clks, sent_cnt=4.
//  3 PRBS DATA_W=8 SEED=1: 255 words, all nonzero and distinct, 256th == 01.
//  4 tx_ready low 7 clks in SEND: tx_valid/tx_data held stable; next burst start delayed by 7.
//  5 enable drops mid-burst (BURST_LEN=8, word 3 pending): word 3 completes, then IDLE, busy=0.
//  6 rst pulse during SEND, and sent_cnt wrap FFFF->0000 with forced preload: all outputs reset.

Source files
------------

// File: rtl/uart_pat_pkg.sv
// uart_pat_pkg: shared types and pattern helpers
// for the UART TX stimulus generator.
package uart_pat_pkg;

  typedef enum logic [1:0] {
    MODE_INC   = 2'd0,
    MODE_DEC   = 2'd1,
    MODE_PRBS  = 2'd2,
    MODE_FIXED = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // Fibonacci taps, bit i = stage i+1
  localparam logic [15:0] TAPS_W8  = 16'h00B8;
  localparam logic [15:0] TAPS_W16 = 16'hD008;

  function automatic logic [15:0] tap_mask(
    input int unsigned w
  );
    return (w == 16) ? TAPS_W16 : TAPS_W8;
  endfunction

  function automatic logic [15:0] next_pattern(
    input mode_e       m,
    input logic [15:0] p,
    input int unsigned w,
    input logic [15:0] fixed
  );
    logic [15:0] msk;
    logic [15:0] n;
    msk = (w == 16) ? 16'hFFFF : 16'h00FF;
    n   = p;
    unique case (m)
      MODE_INC:   n = p + 16'd1;
      MODE_DEC:   n = p - 16'd1;
      MODE_PRBS:  n = {p[14:0], ^(p & tap_mask(w))};
      MODE_FIXED: n = fixed;
      default:    n = p;
    endcase
    return n & msk;
  endfunction

endpackage

// File: rtl/pattern_lfsr.sv
// pattern_lfsr: maximal-length Fibonacci LFSR,
// shift-left, feedback into the LSB.
module pattern_lfsr
  import uart_pat_pkg::*;
#(
  parameter int unsigned       DATA_W = 8,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] nxt
);

  localparam logic [DATA_W-1:0] TAPS =
    DATA_W'(tap_mask(DATA_W));
  // all-zero is the lock-up state
  localparam logic [DATA_W-1:0] INIT =
    (SEED == '0) ? DATA_W'(1) : SEED;

  assign nxt = {q[DATA_W-2:0], ^(q & TAPS)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= INIT;
    end else if (load) begin
      q <= INIT;
    end else if (step) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/tx_pattern_gen.sv
// tx_pattern_gen: periodic burst source of
// INC/DEC/PRBS/FIXED words for a UART TX.
module tx_pattern_gen
  import uart_pat_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       PERIOD    = 50000,
  parameter int unsigned       BURST_LEN = 1,
  parameter logic [DATA_W-1:0] SEED      = DATA_W'(1),
  parameter logic [7:0]        FIXED_VAL = 8'h55
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic [15:0]       sent_cnt
);

  localparam int unsigned CNT_W = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(PERIOD - 1);
  localparam logic [7:0] BURST_LAST =
    8'(BURST_LEN - 1);
  localparam logic [DATA_W-1:0] FIX_W =
    DATA_W'(FIXED_VAL);

  state_e            state;
  state_e            state_nxt;
  mode_e             mode_r;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        burst_cnt;
  logic [DATA_W-1:0] pat_q;
  logic [DATA_W-1:0] pat_cur;
  logic [DATA_W-1:0] pat_nxt;
  logic [DATA_W-1:0] lfsr_q;
  logic [DATA_W-1:0] lfsr_nxt;
  logic              acc;
  logic              last;
  logic              cnt_done;
  logic              load;
  logic              go_send;
  logic              step;

  assign acc      = tx_valid & tx_ready;
  assign last     = (burst_cnt == BURST_LAST) || !enable;
  assign cnt_done = (cnt == CNT_LAST);

  pattern_lfsr #(
    .DATA_W (DATA_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .q    (lfsr_q),
    .nxt  (lfsr_nxt)
  );

  always_comb begin
    pat_cur = pat_q;
    pat_nxt = DATA_W'(next_pattern(
      mode_r, 16'(pat_q), DATA_W, 16'(FIX_W)));
    unique case (1'b1)
      mode_r == MODE_PRBS: begin
        pat_cur = lfsr_q;
        pat_nxt = lfsr_nxt;
      end
      mode_r == MODE_FIXED: begin
        pat_cur = FIX_W;
        pat_nxt = FIX_W;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!enable) state_nxt = ST_IDLE;
        else if (cnt_done) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (acc && last)
          state_nxt = enable ? ST_WAIT : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    load    = 1'b0;
    go_send = 1'b0;
    step    = 1'b0;
    busy    = 1'b0;
    unique case (state)
      ST_IDLE: load = enable;
      ST_WAIT: begin
        busy    = 1'b1;
        go_send = enable && cnt_done;
      end
      ST_SEND: begin
        busy = 1'b1;
        step = acc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r    <= MODE_INC;
      cnt       <= '0;
      burst_cnt <= '0;
      pat_q     <= SEED;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      sent_cnt  <= '0;
    end else begin
      if (load) begin
        mode_r <= mode_e'(mode);
        pat_q  <= SEED;
      end
      if (load || go_send) begin
        cnt <= '0;
      end else if (state == ST_WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (go_send) begin
        tx_valid <= 1'b1;
        tx_data  <= pat_cur;
      end
      // valid never drops until this accept
      if (step) begin
        sent_cnt <= sent_cnt + 16'd1;
        pat_q    <= pat_nxt;
        if (last) begin
          tx_valid  <= 1'b0;
          burst_cnt <= '0;
        end else begin
          burst_cnt <= burst_cnt + 8'd1;
          tx_data   <= pat_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_pattern_gen.sv
// tb_tx_pattern_gen: randomized sessions with a
// queue scoreboard and an independent monitor.
module tb_tx_pattern_gen;

  localparam int PERIOD = 10;
  localparam int BURST  = 4;
  localparam int LIMIT  = 4000;
  localparam logic [7:0] SEED = 8'h02;
  localparam logic [7:0] FIXV = 8'h55;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic [15:0] sent_cnt;

  tx_pattern_gen #(
    .DATA_W    (8),
    .PERIOD    (PERIOD),
    .BURST_LEN (BURST),
    .SEED      (SEED),
    .FIXED_VAL (FIXV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .mode     (mode),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .sent_cnt (sent_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int ready_mode = 2;
  int sess_acc = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  obs_q[$];
  logic [15:0] exp_sent = 16'd0;

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  name, act, exp);
  endtask

  function automatic logic [7:0] model_next(
    input logic [1:0] m,
    input logic [7:0] p
  );
    case (m)
      2'd0:    return p + 8'd1;
      2'd1:    return p - 8'd1;
      2'd2:    return {p[6:0],
                       p[7] ^ p[5] ^ p[4] ^ p[3]};
      default: return FIXV;
    endcase
  endfunction

  always @(posedge clk) cyc++;

  initial forever begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ($urandom_range(0, 3) != 0);
      default: tx_ready = 1'b0;
    endcase
  end

  // monitor
  int         ref_cyc = 0;
  int         burst_idx = 0;
  int         want_valid = -1;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic       prev_en = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_en    = enable;
      want_valid = -1;
      exp_sent   = 16'd0;
      exp_q.delete();
    end else begin
      check("sent_cnt", 32'(sent_cnt), 32'(exp_sent));
      if (enable && !prev_en && !busy) begin
        ref_cyc   = cyc;
        burst_idx = 0;
      end
      if (want_valid >= 0)
        check("next_valid", 32'(tx_valid),
              32'(want_valid));
      want_valid = -1;
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 32'(tx_valid), 32'd1);
        check("hold_data", 32'(tx_data),
              32'(prev_data));
      end
      if (tx_valid && !prev_valid)
        check("burst_start", 32'(cyc - ref_cyc),
              32'(PERIOD + 1));
      if (tx_valid)
        check("busy_in_send", 32'(busy), 32'd1);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL extra_word: got %0h want none",
                   tx_data);
        end else begin
          check("data", 32'(tx_data),
                32'(exp_q.pop_front()));
        end
        obs_q.push_back(tx_data);
        exp_sent = exp_sent + 16'd1;
        sess_acc++;
        burst_idx++;
        if (burst_idx == BURST || !enable) begin
          burst_idx  = 0;
          ref_cyc    = cyc;
          want_valid = 0;
        end else begin
          want_valid = 1;
        end
      end
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
      prev_en    = enable;
    end
  end

  task automatic session(
    input logic [1:0] m,
    input int         n,
    input int         rmode,
    input int         stall_at
  );
    logic [7:0] p;
    int  t;
    bit  stalled;
    p = (m == 2'd2 && SEED == 8'h00) ? 8'h01 : SEED;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back((m == 2'd3) ? FIXV : p);
      p = model_next(m, p);
    end
    sess_acc   = 0;
    obs_q.delete();
    mode       = m;
    ready_mode = rmode;
    enable     = 1'b1;
    t          = 0;
    stalled    = 1'b0;
    while (!(sess_acc == n - 1 && tx_valid)
           && t < LIMIT) begin
      @(posedge clk);
      #1;
      t++;
      if (!stalled && stall_at >= 0
          && sess_acc == stall_at && tx_valid) begin
        stalled    = 1'b1;
        ready_mode = 2;
        repeat (7) begin
          @(posedge clk);
          #1;
        end
        ready_mode = rmode;
      end
    end
    check("session_reach", 32'(t < LIMIT), 32'd1);
    enable = 1'b0;
    t = 0;
    while (busy && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("session_idle", 32'(t < 400), 32'd1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("drained", 32'(exp_q.size()), 32'd0);
    check("idle_valid", 32'(tx_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("sess_words", 32'(sess_acc), 32'(n));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int nd;
    bit seen[256];
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(sent_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    session(2'd0, 6, 0, -1);
    session(2'd1, 4, 0, -1);
    session(2'd3, 5, 1, -1);
    session(2'd0, 5, 0, 1);
    session(2'd0, 3, 0, -1);
    session(2'd2, 256, 1, -1);

    nd = 0;
    for (int i = 0; i < 255 && i < obs_q.size(); i++) begin
      if (obs_q[i] != 8'h00 && !seen[obs_q[i]]) begin
        seen[obs_q[i]] = 1'b1;
        nd++;
      end
    end
    check("prbs_distinct", 32'(nd), 32'd255);
    if (obs_q.size() >= 256)
      check("prbs_wrap", 32'(obs_q[255]), 32'(SEED));
    else
      check("prbs_len", 32'(obs_q.size()), 32'd256);

    // preload near wrap, then reset mid-burst
    exp_q.push_back(SEED);
    exp_q.push_back(SEED + 8'd1);
    exp_q.push_back(SEED + 8'd2);
    sess_acc   = 0;
    mode       = 2'd0;
    ready_mode = 2;
    enable     = 1'b1;
    t = 0;
    while (!tx_valid && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("wrap_start", 32'(tx_valid), 32'd1);
    force dut.sent_cnt = 16'hFFFE;
    exp_sent = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.sent_cnt;
    ready_mode = 0;
    t = 0;
    while (sess_acc < 2 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    ready_mode = 2;
    @(posedge clk);
    #1;
    check("wrap_cnt", 32'(sent_cnt), 32'd0);
    check("pending_valid", 32'(tx_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_data", 32'(tx_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cnt", 32'(sent_cnt), 32'd0);
    enable = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    session(2'd1, 2, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
